// File: rtl/alu_pipe.sv
// alu_pipe: registered Y86 execute-stage ALU with valid/ready handshake and ZF/SF/OF condition codes
// Optional feature macro: ALU_PIPE_MUL_EN. When it is defined, op 100 runs an iterative shift-add multiply.
// When it is undefined, op 100 is reserved.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake; an op is accepted only in IDLE
//   op, a, b, set_cc     opcode (000 add, 001 sub, 010 and, 011 xor, 100 mul), signed operands, CC update enable
//   out_valid/out_ready  result handshake; out_valid is high only in DONE
//   result, overflow     signed result and its signed-overflow flag
//   op_err               a reserved opcode was issued
//   cc_zf, cc_sf, cc_of  condition-code register
module alu_pipe #(
    parameter int WIDTH     = 64,
    parameter int MUL_CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             op_err,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);
    if (2**MUL_CNT_W <= WIDTH) begin : g_bad_cnt
        $error("MUL_CNT_W too small for WIDTH");
    end
`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
    state_t state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, alu_res, sum, diff;
    logic ovf_q, ovf_d, err_q, err_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic alu_ovf, alu_rsv, is_mul;
    assign sum     = a + b;
    assign diff    = a - b;
    assign alu_res = op == 3'd0 ? sum : op == 3'd1 ? diff : op == 3'd2 ? a & b : op == 3'd3 ? a ^ b : '0;
    assign alu_ovf = op == 3'd0 ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
                     op == 3'd1 ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
`ifdef ALU_PIPE_MUL_EN
    assign is_mul = op == 3'd4;
    // The multiplicand is kept sign-extended to 2*WIDTH bits and shifted left each step.
    // The top multiplier bit carries negative weight, so its partial product is subtracted.
    // This yields the exact signed 2*WIDTH-bit product.
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mul_sum;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic setcc_q, setcc_d, mul_last, mul_ovf;
    assign mul_last = cnt_q == MUL_CNT_W'(WIDTH - 1);
    assign mul_sum  = acc_q + (mplier_q[0] ? (mul_last ? -mcand_q : mcand_q) : '0);
    assign mul_ovf  = mul_sum[2*WIDTH-1:WIDTH] != {WIDTH{mul_sum[WIDTH-1]}};
`else
    assign is_mul = 1'b0;
`endif
    assign alu_rsv = op > 3'd3 && !is_mul;
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;
`ifdef ALU_PIPE_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        setcc_d  = setcc_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
`ifdef ALU_PIPE_MUL_EN
                if (is_mul) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{a[WIDTH-1]}}, a};
                    mplier_d = b;
                    cnt_d    = '0;
                    setcc_d  = set_cc;
                    err_d    = 1'b0;
                    state_d  = MUL;
                end else
`endif
                begin
                    result_d = alu_res;
                    ovf_d    = alu_ovf;
                    err_d    = alu_rsv;
                    state_d  = DONE;
                    if (set_cc && !alu_rsv) begin
                        zf_d = alu_res == '0;
                        sf_d = alu_res[WIDTH-1];
                        of_d = alu_ovf;
                    end
                end
            end
`ifdef ALU_PIPE_MUL_EN
            MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + MUL_CNT_W'(1);
                if (mul_last) begin
                    state_d  = DONE;
                    result_d = mul_sum[WIDTH-1:0];
                    ovf_d    = mul_ovf;
                    if (setcc_q) begin
                        zf_d = mul_sum[WIDTH-1:0] == '0;
                        sf_d = mul_sum[WIDTH-1];
                        of_d = mul_ovf;
                    end
                end
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            zf_q     <= 1'b1;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            setcc_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
`ifdef ALU_PIPE_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            setcc_q  <= setcc_d;
`endif
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign op_err    = err_q;
    assign cc_zf     = zf_q;
    assign cc_sf     = sf_q;
    assign cc_of     = of_q;
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational Y86 ALU. Supports add, sub, and, and xor as single-cycle operations, plus an iterative multi-cycle multiply.
- Uses a valid/ready handshake on both input and output, and holds a Y86 condition-code register (ZF/SF/OF).
- Sits between decode and writeback in the execute stage. The CC register feeds the branch/cmov condition logic.

Parameters:
- WIDTH, 64, operand/result width in bits (8..64).
- MUL_CNT_W, 7, multiply iteration counter width; must satisfy 2^MUL_CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept a bundle
- op  input  3  000 add, 001 sub, 010 and, 011 xor, 100 mul, 101..111 reserved
- a  input  WIDTH  signed operand A
- b  input  WIDTH  signed operand B
- set_cc  input  1  update CC from this operation
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  signed result
- overflow  output  1  signed overflow of result
- op_err  output  1  reserved opcode was issued
- cc_zf  output  1  zero flag
- cc_sf  output  1  sign flag
- cc_of  output  1  overflow flag

Behaviour:
- Reset (async, any state, aborts an in-flight multiply):
  - state=IDLE, result=0, overflow=0, op_err=0, out_valid=0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - in_ready=1 once rst deasserts.
- FSM has three states: IDLE, MUL, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE with in_valid=1 accepts the bundle and latches op/a/b/set_cc.
  - For add/sub/and/xor/reserved: result, overflow, and op_err are registered at the accept edge, and the next state is DONE. Latency is 1 cycle.
  - For mul: operands are latched, the counter is cleared, and the next state is MUL.
- MUL performs one shift-add step per cycle over WIDTH cycles, then goes to DONE. Latency is WIDTH+1 cycles from accept to out_valid. in_valid is ignored during MUL.
- DONE holds result, flags, and out_valid stable until out_ready=1. At that edge the next state is IDLE. No new accept occurs in the same cycle, so maximum throughput is one operation per 2 cycles.
- Arithmetic (two's complement, WIDTH-bit wrap):
  - add: a+b. overflow = a,b same sign and result sign differs.
  - sub: a-b. overflow = a,b differ in sign and result sign differs from a.
  - and/xor: bitwise; overflow=0.
  - mul: result = low WIDTH bits of the signed product. overflow=1 iff the full 2*WIDTH-bit signed product is not the sign-extension of result.
  - reserved opcode: result=0, overflow=0, op_err=1. op_err is cleared on the next accept of a valid op.
- CC update:
  - Occurs on the edge that sets out_valid, and only if the latched set_cc=1 and the op is not reserved.
  - ZF = (result==0), SF = result[WIDTH-1], OF = overflow.
  - Otherwise CC holds its value.
- CC is readable in every state. The update is visible in the same cycle out_valid first rises.
- in_valid asserted while in_ready=0 has no effect; the upstream stage must hold its bundle.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: the mul opcode and the MUL state exist as specified.
- Undefined: no multiplier datapath or MUL state is synthesised. Op 100 is treated as reserved (result=0, op_err=1, 1-cycle latency, no CC update).

Test Plan:
- Reset then idle, WIDTH=64 → result=0, out_valid=0, in_ready=1, cc_zf=1, cc_sf=0, cc_of=0. Assert rst during MUL → immediate return to these values.
- add a=0x7FFFFFFFFFFFFFFF, b=1, set_cc=1 → next cycle out_valid=1, result=0x8000000000000000, overflow=1, SF=1, ZF=0, OF=1.
- sub a=5, b=5, set_cc=1, with out_ready held 0 for 3 cycles → result=0 stable, ZF=1. A second in_valid during DONE is not accepted (in_ready=0).
- xor a=0xFF, b=0xFF, set_cc=0 after a prior add setting ZF=0 → result=0, CC unchanged (ZF stays 0).
- mul (ALU_PIPE_MUL_EN) a=-3, b=7 → out_valid 65 cycles after accept, result=-21, overflow=0. Then a=0x4000000000000000, b=4 → result=0, overflow=1.
- op=110 → result=0, op_err=1, CC unchanged. Then a valid add → op_err=0. Without the macro, op=100 behaves identically to op=110.
